pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Consumer and controller side of the rPLL lock/reset interface: watches the PLL `lock` output and drives the PLL `RESET` input.
- Runs on the free-running 27 MHz reference clock, never on the PLL output.
- Holds the system reset until lock has been stable for a qualified time.
- Re-initialises the PLL after lock loss or lock timeout.
- Sits at top level between the board oscillator, the PLL instance and the downstream reset synchronisers.

Parameters:
- RST_CYCLES, 27: clk cycles `pll_reset` is held high per PLL reset pulse (1 us at 27 MHz).
- LOCK_STABLE, 2700: consecutive synchronised-lock-high cycles required before releasing `sys_reset` (100 us).
- LOCK_TIMEOUT, 270000: clk cycles allowed in WAIT_LOCK before retrying (10 ms); must exceed LOCK_STABLE.
- RETRY_W, 4: width of the retry counter.

Ports:
- clk, input, 1: 27 MHz reference clock.
- reset, input, 1: asynchronous, active-high reset.
- lock, input, 1: PLL lock; asynchronous to clk.
- force_reset, input, 1: synchronous request to restart the PLL sequence.
- pll_reset, output, 1: to PLL RESET; high = PLL held in reset.
- sys_reset, output, 1: active-high system reset, released only in RUN.
- locked, output, 1: high while in RUN.
- lock_lost, output, 1: sticky; set on any lock drop seen in RUN.
- retry_count, output, RETRY_W: saturating count of WAIT_LOCK timeouts.
- state, output, 2: current state encoding, for debug.

Behaviour:
- Reset is asynchronous, active-high, on a single clock (`clk`).
- While reset is high:
  - state = PLL_RST, all counters = 0, lock synchroniser = 00.
  - pll_reset = 1, sys_reset = 1, locked = 0, lock_lost = 0, retry_count = 0.
- All outputs are registered; no combinational path from any input to any output.
- `lock` passes through a 2-FF synchroniser; lock_s is the second flop. This adds 2 cycles of latency.
- State encoding: PLL_RST = 0, WAIT_LOCK = 1, RUN = 2. Value 3 is illegal and recovers to PLL_RST on the next cycle.
- PLL_RST:
  - pll_reset = 1, sys_reset = 1; cnt increments each cycle.
  - When cnt == RST_CYCLES-1: go to WAIT_LOCK and clear cnt and stable_cnt.
  - pll_reset is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_reset = 0, sys_reset = 1; cnt (timeout) increments every cycle.
  - stable_cnt clears whenever lock_s = 0 and increments whenever lock_s = 1.
  - When lock_s = 1 and stable_cnt == LOCK_STABLE-1: go to RUN.
  - Otherwise, when cnt == LOCK_TIMEOUT-1: go to PLL_RST, clear cnt, and increment retry_count (saturating at all-ones).
  - If both conditions hold in the same cycle, the stable condition wins.
- RUN:
  - pll_reset = 0, sys_reset = 0, locked = 1.
  - lock_s = 0 for one cycle: go to PLL_RST, set lock_lost, clear cnt. sys_reset and locked change in the cycle after lock_s falls.
- force_reset = 1 in any state:
  - go to PLL_RST next cycle and clear cnt and stable_cnt.
  - retry_count and lock_lost are not modified.
  - force_reset takes priority over every other transition.
  - If held high, PLL_RST restarts every cycle, so pll_reset stays high.
- Counters: cnt width is $clog2(max(RST_CYCLES, LOCK_TIMEOUT)); stable_cnt width is $clog2(LOCK_STABLE). Neither counter wraps inside its state.
- lock_lost and retry_count are cleared only by reset.
- Reset asserted mid-sequence returns everything to the reset values immediately (asynchronously).

Decomposition:
- Shared package:
  - state enum (PLL_RST, WAIT_LOCK, RUN);
  - default timing constants for 27 MHz: CLK_REF_HZ = 27000000, plus the 1 us, 100 us and 10 ms cycle counts.
- Sub-module: sync_2ff, a generic 2-flop single-bit synchroniser with async active-high reset, reused for `lock`.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32.
1. Release reset with lock = 0, then raise lock 10 cycles later -> pll_reset high for exactly 4 cycles, sys_reset falls 2+8 cycles after the lock rise, locked = 1, retry_count = 0.
2. Hold lock = 0 -> pll_reset pulses of 4 cycles every 36 cycles, retry_count = 1, 2, ... and saturates at 15 after 15 timeouts.
3. In RUN, drop lock for 1 cycle -> sys_reset = 1 three cycles later, lock_lost = 1, pll_reset 4-cycle pulse, then re-qualification of 8 stable cycles.
4. In WAIT_LOCK, toggle lock 1,1,1,0,1... -> stable_cnt restarts after each 0, RUN entered only after 8 uninterrupted high cycles.
5. force_reset pulse in RUN -> PLL_RST next cycle, lock_lost and retry_count unchanged, normal re-lock follows.
6. Assert reset asynchronously mid-WAIT_LOCK -> all outputs return to reset values before the next clk edge, state = 0.

Source files
------------

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and 27 MHz timing defaults for the PLL lock supervisor.
// State encoding is exported on the debug port, so values are pinned here.
package pll_lock_supervisor_pkg;

    localparam int CLK_REF_HZ = 27000000;
    localparam int CYC_1US    = CLK_REF_HZ / 1000000;
    localparam int CYC_100US  = CLK_REF_HZ / 10000;
    localparam int CYC_10MS   = CLK_REF_HZ / 100;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        RUN       = 2'd2
    } state_e;

    // Counter width that holds 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL lock/reset bundle: lock and restart request in, PLL and system resets out.
// No handshake; every supervisor output is a flop, inputs are level signals.
interface pll_lock_supervisor_if
    import pll_lock_supervisor_pkg::*;
#(
    parameter int RETRY_W = 4
);
    logic               lock;
    logic               force_reset;
    logic               pll_reset;
    logic               sys_reset;
    logic               locked;
    logic               lock_lost;
    logic [RETRY_W-1:0] retry_count;
    state_e             state;

    modport master (
        output lock, force_reset,
        input  pll_reset, sys_reset, locked, lock_lost, retry_count, state
    );

    modport slave (
        input  lock, force_reset,
        output pll_reset, sys_reset, locked, lock_lost, retry_count, state
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchroniser, async active-high reset clears both stages.
// Latency: two clk edges from d_i to q_o.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock stability and gates the system reset.
// Outputs are registered from next-state; lock adds two synchroniser cycles.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int RST_CYCLES   = CYC_1US,
    parameter int LOCK_STABLE  = CYC_100US,
    parameter int LOCK_TIMEOUT = CYC_10MS,
    parameter int RETRY_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pll_lock_supervisor_if.slave bus
);
    localparam int CNT_W = cnt_width((RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT);
    localparam int STB_W = cnt_width(LOCK_STABLE);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STB_W-1:0]   stable_q, stable_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lost_q, lost_d;
    logic               pll_reset_q, sys_reset_q, locked_q;
    logic               lock_s;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (reset),
        .d_i (bus.lock),
        .q_o (lock_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        retry_d  = retry_q;
        lost_d   = lost_q;
        if (bus.force_reset) begin
            state_d  = PLL_RST;
            cnt_d    = '0;
            stable_d = '0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d  = WAIT_LOCK;
                        cnt_d    = '0;
                        stable_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    // Stable qualification beats a coincident timeout.
                    if (lock_s && (stable_q == STB_LAST)) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        stable_d = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d  = PLL_RST;
                        cnt_d    = '0;
                        stable_d = '0;
                        if (retry_q != '1) begin
                            retry_d = retry_q + RETRY_W'(1);
                        end
                    end else begin
                        cnt_d    = cnt_q + CNT_W'(1);
                        stable_d = lock_s ? (stable_q + STB_W'(1)) : '0;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = PLL_RST;
                        cnt_d   = '0;
                        lost_d  = 1'b1;
                    end
                end
                default: begin
                    state_d  = PLL_RST;
                    cnt_d    = '0;
                    stable_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            stable_q    <= '0;
            retry_q     <= '0;
            lost_q      <= 1'b0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            pll_reset_q <= (state_d == PLL_RST);
            sys_reset_q <= (state_d != RUN);
            locked_q    <= (state_d == RUN);
        end
    end

    assign bus.pll_reset   = pll_reset_q;
    assign bus.sys_reset   = sys_reset_q;
    assign bus.locked      = locked_q;
    assign bus.lock_lost   = lost_q;
    assign bus.retry_count = retry_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomised and directed checks of pll_lock_supervisor against a phase-level model.
module tb_pll_lock_supervisor;
    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int RW = 4;
    localparam int RMAX = (1 << RW) - 1;
    localparam int PH_RST = 0, PH_WAIT = 1, PH_RUN = 2;
    localparam logic [9:0] RST_VEC = 10'b1100_0000_00;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_pass = 0;

    pll_lock_supervisor_if #(.RETRY_W(RW)) bus ();

    pll_lock_supervisor #(
        .RST_CYCLES(RC), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .RETRY_W(RW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: phase, time in phase, consecutive-high run, retries, sticky loss,
    // and the last two lock samples standing in for the synchroniser delay.
    int m_ph, m_t, m_st, m_retry;
    bit m_lost, m_h0, m_h1;

    task automatic model_rst();
        m_ph = PH_RST; m_t = 0; m_st = 0; m_retry = 0; m_lost = 0; m_h0 = 0; m_h1 = 0;
    endtask

    task automatic model_edge();
        bit ls;
        ls = m_h1;
        if (reset) begin
            model_rst();
            return;
        end
        if (bus.force_reset) begin
            m_ph = PH_RST; m_t = 0; m_st = 0;
        end else if (m_ph == PH_RST) begin
            if (m_t == RC - 1) begin m_ph = PH_WAIT; m_t = 0; m_st = 0; end
            else m_t++;
        end else if (m_ph == PH_WAIT) begin
            if (ls && m_st == LS - 1) m_ph = PH_RUN;
            else if (m_t == LT - 1) begin
                m_ph = PH_RST; m_t = 0;
                if (m_retry < RMAX) m_retry++;
            end else begin
                m_t++;
                m_st = ls ? m_st + 1 : 0;
            end
        end else if (!ls) begin
            m_ph = PH_RST; m_t = 0; m_lost = 1;
        end
        m_h1 = m_h0;
        m_h0 = bus.lock;
    endtask

    function automatic logic [9:0] expv();
        return {m_ph == PH_RST, m_ph != PH_RUN, m_ph == PH_RUN, m_lost, 4'(m_retry), 2'(m_ph)};
    endfunction

    function automatic logic [9:0] obs();
        return {bus.pll_reset, bus.sys_reset, bus.locked, bus.lock_lost, bus.retry_count, bus.state};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        bus.lock = 1'b0; bus.force_reset = 1'b0; reset = 1'b1;
        model_rst();
        repeat (2) step();
        n_checks++;
        if (obs() !== RST_VEC) $display("FAIL reset_vec got %b exp %b", obs(), RST_VEC); else n_pass++;
        n_checks++;
        if (bus.pll_reset !== 1'b1 || bus.sys_reset !== 1'b1) $display("FAIL reset_outs got %b%b exp 11", bus.pll_reset, bus.sys_reset); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_lock_acquire();
        int lat;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (obs() !== expv()) $display("FAIL acquire_pre cyc %0d got %b exp %b", i, obs(), expv()); else n_pass++;
        end
        bus.lock = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            n_checks++;
            if (obs() !== expv()) $display("FAIL acquire cyc %0d got %b exp %b", i, obs(), expv()); else n_pass++;
            if (lat < 0 && bus.sys_reset === 1'b0) lat = i;
        end
        n_checks++;
        if (lat !== 2 + LS) $display("FAIL acquire_latency got %0d exp %0d", lat, 2 + LS); else n_pass++;
        n_checks++;
        if (bus.locked !== 1'b1 || bus.retry_count !== 4'd0) $display("FAIL acquire_final got locked=%b retry=%0d exp 1/0", bus.locked, bus.retry_count); else n_pass++;
    endtask

    task automatic test_timeouts();
        int rise0, rise1, width, hi_run;
        bit prev;
        rise0 = -1; rise1 = -1; width = -1; hi_run = 0; prev = bus.pll_reset;
        bus.lock = 1'b0;
        for (int i = 0; i < 16 * (RC + LT) + 20; i++) begin
            step();
            n_checks++;
            if (obs() !== expv()) $display("FAIL timeout cyc %0d got %b exp %b", i, obs(), expv()); else n_pass++;
            if (bus.pll_reset && !prev) begin
                if (rise0 < 0 && i > 10) rise0 = i;
                else if (rise0 >= 0 && rise1 < 0) rise1 = i;
            end
            hi_run = bus.pll_reset ? hi_run + 1 : 0;
            if (!bus.pll_reset && prev && rise0 >= 0 && width < 0) width = hi_run_prev_fix(i, rise0);
            prev = bus.pll_reset;
        end
        n_checks++;
        if (width !== RC) $display("FAIL pll_reset_width got %0d exp %0d", width, RC); else n_pass++;
        n_checks++;
        if (rise1 - rise0 !== RC + LT) $display("FAIL retry_period got %0d exp %0d", rise1 - rise0, RC + LT); else n_pass++;
        n_checks++;
        if (bus.retry_count !== 4'(RMAX)) $display("FAIL retry_saturate got %0d exp %0d", bus.retry_count, RMAX); else n_pass++;
    endtask

    function automatic int hi_run_prev_fix(input int fall_idx, input int rise_idx);
        return fall_idx - rise_idx;
    endfunction

    task automatic test_stable_toggle();
        logic [0:23] pat;
        int run, exp_i, got_i;
        pat = 24'b1110_1111_1101_1111_1111_1111;
        bus.force_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (obs() !== expv()) $display("FAIL force_hold cyc %0d got %b exp %b", i, obs(), expv()); else n_pass++;
        end
        n_checks++;
        if (bus.pll_reset !== 1'b1 || bus.state !== 2'd0) $display("FAIL force_hold_pll got %b/%0d exp 1/0", bus.pll_reset, bus.state); else n_pass++;
        bus.force_reset = 1'b0;
        for (int i = 0; i < RC + 1; i++) step();
        run = 0; exp_i = -1; got_i = -1;
        for (int p = 0; p < 24; p++) begin
            run = pat[p] ? run + 1 : 0;
            if (run == LS && exp_i < 0) exp_i = p + 2;
        end
        for (int p = 0; p < 24; p++) begin
            bus.lock = pat[p];
            step();
            n_checks++;
            if (obs() !== expv()) $display("FAIL toggle cyc %0d got %b exp %b", p, obs(), expv()); else n_pass++;
            if (got_i < 0 && bus.locked === 1'b1) got_i = p;
        end
        n_checks++;
        if (got_i !== exp_i) $display("FAIL toggle_run_entry got %0d exp %0d", got_i, exp_i); else n_pass++;
    endtask

    task automatic test_force_reset();
        bus.force_reset = 1'b1;
        step();
        bus.force_reset = 1'b0;
        n_checks++;
        if (bus.state !== 2'd0 || bus.sys_reset !== 1'b1) $display("FAIL force_pulse got state=%0d sys=%b exp 0/1", bus.state, bus.sys_reset); else n_pass++;
        n_checks++;
        if (bus.lock_lost !== 1'b1 || bus.retry_count !== 4'(RMAX)) $display("FAIL force_keep got lost=%b retry=%0d exp 1/%0d", bus.lock_lost, bus.retry_count, RMAX); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (obs() !== expv()) $display("FAIL force_relock cyc %0d got %b exp %b", i, obs(), expv()); else n_pass++;
        end
        n_checks++;
        if (bus.locked !== 1'b1) $display("FAIL force_relock_locked got %b exp 1", bus.locked); else n_pass++;
    endtask

    task automatic test_lock_drop();
        logic [2:0] sr;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.lock = 1'b1;
        for (int i = 0; i < 20; i++) step();
        n_checks++;
        if (bus.locked !== 1'b1 || bus.lock_lost !== 1'b0) $display("FAIL drop_pre got locked=%b lost=%b exp 1/0", bus.locked, bus.lock_lost); else n_pass++;
        bus.lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.lock = 1'b1;
            sr[i] = bus.sys_reset;
            n_checks++;
            if (obs() !== expv()) $display("FAIL drop cyc %0d got %b exp %b", i, obs(), expv()); else n_pass++;
        end
        n_checks++;
        if (sr !== 3'b100) $display("FAIL drop_sys_reset_timing got %b exp 100", sr); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (obs() !== expv()) $display("FAIL drop_requal cyc %0d got %b exp %b", i, obs(), expv()); else n_pass++;
        end
        n_checks++;
        if (bus.lock_lost !== 1'b1 || bus.locked !== 1'b1) $display("FAIL drop_final got lost=%b locked=%b exp 1/1", bus.lock_lost, bus.locked); else n_pass++;
    endtask

    task automatic test_async_reset();
        bus.lock = 1'b0;
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (bus.state !== 2'd1) $display("FAIL async_pre got state=%0d exp 1", bus.state); else n_pass++;
        #2 reset = 1'b1;
        #1;
        model_rst();
        n_checks++;
        if (obs() !== RST_VEC) $display("FAIL async_reset got %b exp %b", obs(), RST_VEC); else n_pass++;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (obs() !== expv()) $display("FAIL async_after cyc %0d got %b exp %b", i, obs(), expv()); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) bus.lock = ~bus.lock;
            bus.force_reset = ($urandom_range(127) == 0);
            step();
            n_checks++;
            if (obs() !== expv()) $display("FAIL random cyc %0d got %b exp %b", i, obs(), expv()); else n_pass++;
        end
        bus.force_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_timeouts();
        test_stable_toggle();
        test_force_reset();
        test_lock_drop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
